// File: rtl/pyramid_reader.sv
// Pyramid reader: streams a contiguous octave/level image pyramid
// from a 2-cycle-latency memory into a flow-controlled pixel stream.
module pyramid_reader #(
  parameter int BIT_DEPTH   = 8,
  parameter int IMG_WIDTH   = 64,
  parameter int IMG_HEIGHT  = 64,
  parameter int NUM_OCTAVES = 3,
  parameter int NUM_LEVELS  = 3,
  parameter int ADDR_WIDTH  = 14
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  start_in,
  input  logic                  abort_in,
  output logic                  rd_en_out,
  output logic [ADDR_WIDTH-1:0] rd_addr_out,
  input  logic [BIT_DEPTH-1:0]  rd_data_in,
  output logic [BIT_DEPTH-1:0]  pixel_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [1:0]            octave_out,
  output logic [1:0]            level_out,
  output logic [7:0]            x_out,
  output logic [7:0]            y_out,
  output logic                  sof_out,
  output logic                  eof_out,
  output logic                  last_out,
  output logic                  busy_out,
  output logic                  done_out
);

  function automatic int total_f();
    int s;
    s = 0;
    for (int o = 0; o < NUM_OCTAVES; o++)
      s += NUM_LEVELS * (IMG_WIDTH >> o) * (IMG_HEIGHT >> o);
    return s;
  endfunction

  localparam int TOTAL = total_f();
  localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(TOTAL - 1);
  localparam logic [1:0] LVL_MAX = 2'(NUM_LEVELS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  typedef struct packed {
    logic [1:0] oct;
    logic [1:0] lvl;
    logic [7:0] x;
    logic [7:0] y;
    logic       sof;
    logic       eof;
    logic       last;
  } meta_t;

  typedef struct packed {
    logic [BIT_DEPTH-1:0] pix;
    meta_t                m;
  } ent_t;

  state_e                state_q;
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            oct_q;
  logic [1:0]            lvl_q;
  logic [7:0]            x_q;
  logic [7:0]            y_q;
  logic                  p1_v_q;
  logic                  p2_v_q;
  meta_t                 p1_q;
  meta_t                 p2_q;
  ent_t                  mem_q [4];
  logic [1:0]            wp_q;
  logic [1:0]            rp_q;
  logic [2:0]            cnt_q;
  logic                  busy_q;
  logic                  done_q;

  logic [7:0] x_max;
  logic [7:0] y_max;
  meta_t      cur_m;
  ent_t       head;
  logic       pop;
  logic [3:0] occ;
  logic       can_iss;

  assign x_max = 8'((IMG_WIDTH >> oct_q) - 1);
  assign y_max = 8'((IMG_HEIGHT >> oct_q) - 1);

  always_comb begin
    cur_m      = '0;
    cur_m.oct  = oct_q;
    cur_m.lvl  = lvl_q;
    cur_m.x    = x_q;
    cur_m.y    = y_q;
    cur_m.sof  = (x_q == 8'd0) && (y_q == 8'd0);
    cur_m.eof  = (x_q == x_max) && (y_q == y_max);
    cur_m.last = (addr_q == LAST_A);
  end

  assign head = mem_q[rp_q];
  assign pop  = (cnt_q != 3'd0) && ready_in;

  // Occupancy once everything in flight lands, net of this cycle's pop.
  assign occ = 4'(cnt_q) + 4'(p2_v_q) + 4'(p1_v_q)
             + 4'(rd_en_q) - 4'(pop);
  assign can_iss = occ < 4'd4;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      oct_q   <= '0;
      lvl_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      p1_v_q  <= 1'b0;
      p2_v_q  <= 1'b0;
      p1_q    <= '0;
      p2_q    <= '0;
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (abort_in) begin
      state_q <= IDLE;
      rd_en_q <= 1'b0;
      p1_v_q  <= 1'b0;
      p2_v_q  <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      p1_v_q <= rd_en_q;
      p1_q   <= cur_m;
      p2_v_q <= p1_v_q;
      p2_q   <= p1_q;
      if (p2_v_q) begin
        mem_q[wp_q] <= {rd_data_in, p2_q};
        wp_q        <= wp_q + 2'd1;
      end
      if (pop) rp_q <= rp_q + 2'd1;
      cnt_q <= cnt_q + 3'(p2_v_q) - 3'(pop);
      unique case (state_q)
        IDLE: begin
          if (start_in) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
            addr_q  <= '0;
            oct_q   <= '0;
            lvl_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
          end
        end
        RUN: begin
          if (rd_en_q && cur_m.last) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            rd_en_q <= can_iss;
            if (rd_en_q) begin
              addr_q <= addr_q + ADDR_WIDTH'(1);
              if (x_q != x_max) begin
                x_q <= x_q + 8'd1;
              end else begin
                x_q <= '0;
                if (y_q != y_max) begin
                  y_q <= y_q + 8'd1;
                end else begin
                  y_q <= '0;
                  if (lvl_q != LVL_MAX) begin
                    lvl_q <= lvl_q + 2'd1;
                  end else begin
                    lvl_q <= '0;
                    oct_q <= oct_q + 2'd1;
                  end
                end
              end
            end
          end
        end
        DRAIN: begin
          if (pop && head.m.last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_en_out   = rd_en_q;
  assign rd_addr_out = addr_q;
  assign pixel_out   = head.pix;
  assign valid_out   = cnt_q != 3'd0;
  assign octave_out  = head.m.oct;
  assign level_out   = head.m.lvl;
  assign x_out       = head.m.x;
  assign y_out       = head.m.y;
  assign sof_out     = head.m.sof;
  assign eof_out     = head.m.eof;
  assign last_out    = head.m.last;
  assign busy_out    = busy_q;
  assign done_out    = done_q;

endmodule
